// File: rtl/ysyx_22040931_mem_arb.sv
// Shares one core-side memory bus between IF fetches and LSU loads/stores, one transaction at a time.
// Define YSYX_22040931_ARB_RR_EN for round-robin arbitration; default is fixed LSU priority.
module ysyx_22040931_mem_arb #(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rsp_valid,
  output logic [31:0]       if_rsp_data,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic              lsu_wr,
  input  logic [1:0]        lsu_size,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [63:0]       lsu_wdata,
  output logic              lsu_rsp_valid,
  output logic [63:0]       lsu_rsp_data,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_wr,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [63:0]       bus_wdata,
  output logic [7:0]        bus_wmask,
  input  logic              bus_rsp_valid,
  input  logic [63:0]       bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t state, state_nxt;

  logic              owner_lsu;
  logic              wr_q;
  logic [2:0]        off_q;
  logic              addr2_q;
  logic [ADDR_W-1:0] addr_q;
  logic [63:0]       wdata_q;
  logic [7:0]        wmask_q;
  logic [31:0]       if_data_q;
  logic [63:0]       lsu_data_q;

  logic              grant_lsu, grant_if, accept, capture;
  logic              sel_wr;
  logic [1:0]        sel_size;
  logic [ADDR_W-1:0] sel_addr;
  logic [2:0]        sel_off;
  logic [7:0]        sel_mask;

  function automatic logic [2:0] byte_off(input logic [1:0] sz, input logic [2:0] a);
    logic [2:0] o;
    case (sz)
      2'b00:   o = a;
      2'b01:   o = {a[2:1], 1'b0};
      2'b10:   o = {a[2], 2'b00};
      default: o = 3'b000;
    endcase
    return o;
  endfunction

  function automatic logic [7:0] byte_mask(input logic [1:0] sz, input logic [2:0] o);
    logic [7:0] m;
    case (sz)
      2'b00:   m = 8'h01 << o;
      2'b01:   m = 8'h03 << o;
      2'b10:   m = 8'h0F << o;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

`ifdef YSYX_22040931_ARB_RR_EN
  // last_lsu: 1 when the previous accept went to the LSU; the other side wins the next conflict
  logic last_lsu;
  assign grant_lsu = lsu_req_valid && (!if_req_valid || !last_lsu);

  always_ff @(posedge clk) begin
    if (rst)         last_lsu <= 1'b0;
    else if (accept) last_lsu <= grant_lsu;
  end
`else
  assign grant_lsu = lsu_req_valid;
`endif

  assign grant_if      = if_req_valid && !grant_lsu;
  assign lsu_req_ready = (state == IDLE) && !rst && grant_lsu;
  assign if_req_ready  = (state == IDLE) && !rst && grant_if;
  assign accept        = lsu_req_ready || if_req_ready;

  // IF is always a word read
  assign sel_wr   = grant_lsu && lsu_wr;
  assign sel_size = grant_lsu ? lsu_size : 2'b10;
  assign sel_addr = grant_lsu ? lsu_addr : if_addr;
  assign sel_off  = byte_off(sel_size, sel_addr[2:0]);
  assign sel_mask = sel_wr ? byte_mask(sel_size, sel_off) : 8'h00;

  assign capture = ((state == REQ) && bus_req_ready && bus_rsp_valid) ||
                   ((state == WAIT) && bus_rsp_valid);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = REQ;
      REQ:  if (bus_req_ready) state_nxt = bus_rsp_valid ? RESP : WAIT;
      WAIT: if (bus_rsp_valid) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner_lsu  <= 1'b0;
      wr_q       <= 1'b0;
      off_q      <= 3'b000;
      addr2_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      if_data_q  <= '0;
      lsu_data_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner_lsu <= grant_lsu;
        wr_q      <= sel_wr;
        off_q     <= sel_off;
        addr2_q   <= sel_addr[2];
        addr_q    <= {sel_addr[ADDR_W-1:3], 3'b000};
        wdata_q   <= sel_wr ? (lsu_wdata << {sel_off, 3'b000}) : 64'd0;
        wmask_q   <= sel_mask;
      end
      // Response data is formatted on capture so it holds between pulses
      if (capture) begin
        if (owner_lsu) lsu_data_q <= wr_q ? 64'd0 : (bus_rdata >> {off_q, 3'b000});
        else           if_data_q  <= addr2_q ? bus_rdata[63:32] : bus_rdata[31:0];
      end
    end
  end

  assign bus_req_valid = (state == REQ);
  assign bus_wr        = wr_q;
  assign bus_addr      = addr_q;
  assign bus_wdata     = wdata_q;
  assign bus_wmask     = wmask_q;
  assign if_rsp_valid  = (state == RESP) && !owner_lsu;
  assign lsu_rsp_valid = (state == RESP) && owner_lsu;
  assign if_rsp_data   = if_data_q;
  assign lsu_rsp_data  = lsu_data_q;

endmodule

// File: doc/ysyx_22040931_mem_arb.md
# ysyx_22040931_mem_arb

Two-requester memory access controller. It shares the single core-side memory bus between the instruction-fetch stage (IF, read-only) and the MEM stage load/store path (LSU).
- Arbitrates between the two requesters and carries one outstanding transaction at a time through a request/response FSM.
- Aligns the bus address to 8 bytes, builds the byte-write mask and lane-shifted write data, and right-aligns read data before returning it.
- Sits between IF/MEM and the memory/AXI bridge.

## Interface

Parameters
- ADDR_W, 64, address width of all address ports.

Ports
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- if_req_valid  in  1  IF fetch request.
- if_req_ready  out  1  IF request accepted this cycle.
- if_addr  in  ADDR_W  fetch address (4-byte aligned).
- if_rsp_valid  out  1  one-cycle pulse: fetch data valid.
- if_rsp_data  out  32  instruction word.
- lsu_req_valid  in  1  LSU request.
- lsu_req_ready  out  1  LSU request accepted this cycle.
- lsu_wr  in  1  1 = store, 0 = load.
- lsu_size  in  2  00 byte, 01 half, 10 word, 11 double.
- lsu_addr  in  ADDR_W  byte address.
- lsu_wdata  in  64  store data, right-aligned.
- lsu_rsp_valid  out  1  one-cycle pulse: load data returned or store completed.
- lsu_rsp_data  out  64  load data, right-aligned (bus_rdata >> 8*addr[2:0]); 0 for stores.
- bus_req_valid  out  1  bus request.
- bus_req_ready  in  1  bus accepts request.
- bus_wr  out  1  write.
- bus_addr  out  ADDR_W  request address with [2:0] forced to 0.
- bus_wdata  out  64  lane-shifted write data.
- bus_wmask  out  8  byte enables; 0 on reads.
- bus_rsp_valid  in  1  bus response.
- bus_rdata  in  64  aligned 8-byte read data.

## Operation

- FSM states: IDLE, REQ, WAIT, RESP. Reset state: IDLE.
- IDLE
  - Requester readies are combinational: the winning requester's ready equals its own valid, the other's ready is 0.
  - On valid&ready, latch owner, wr, size, addr and wdata; next state is REQ.
  - IF is always treated as a read of size word.
- REQ
  - bus_req_valid = 1; all bus_* outputs come from latched registers and are stable until accepted.
  - bus_req_ready=1 and bus_rsp_valid=1 → RESP, with bus_rdata captured.
  - bus_req_ready=1 only → WAIT.
  - Otherwise hold.
- WAIT: on bus_rsp_valid → RESP, with bus_rdata captured.
- RESP
  - Owner's rsp_valid = 1 for exactly this cycle; next state is IDLE.
  - New requests are not accepted in RESP.
- bus_rsp_valid outside REQ/WAIT is ignored.
- Byte offset, with a = addr[2:0]:
  - byte: off = a
  - half: off = {a[2:1],0}
  - word: off = {a[2],00}
  - double: off = 0
  - Misaligned low bits are dropped silently.
- bus_wmask for stores:
  - byte: 8'h01<<off
  - half: 8'h03<<off
  - word: 8'h0F<<off
  - double: 8'hFF
- bus_wdata = lsu_wdata << 8*off.
- if_rsp_data = addr[2] ? rdata[63:32] : rdata[31:0].
- lsu_rsp_data = rdata >> 8*off (full shift, no extension; MEM stage sign/zero extends).
- Arbitration default is fixed priority: LSU wins over IF when both are valid in IDLE.

## Timing

- Reset values:
  - state IDLE.
  - bus_req_valid 0, bus_wr 0, bus_addr 0, bus_wdata 0, bus_wmask 0.
  - if_rsp_valid 0, lsu_rsp_valid 0, if_rsp_data 0, lsu_rsp_data 0.
  - Readies are 0 while rst is high.
- Minimum latency: accept at cycle N; bus_req_valid at N+1; with ready and rsp both high at N+1, rsp_valid is at N+2.
- With bus response in a later cycle M, rsp_valid is at M+1.
- Back-to-back throughput: one transaction per 3 cycles minimum (IDLE, REQ, RESP).
- Requester valid may drop without acceptance; nothing is latched.
- Reset mid-transaction returns to IDLE next edge and deasserts bus_req_valid. A stale bus_rsp_valid after reset is ignored and produces no rsp pulse.
- rsp_data outputs hold their last value when rsp_valid is 0.

## Configuration

- YSYX_22040931_ARB_RR_EN defined:
  - Round-robin arbitration. A one-bit last-grant register is updated on each accept.
  - On conflict, the requester not granted last wins.
  - Reset value of last-grant is IF, so LSU wins the first conflict.
- Undefined: fixed LSU priority; the last-grant register is absent.

## Test plan

- IF fetch, addr 0x80000004, bus ready at REQ cycle and rsp 2 cycles later with rdata 0x11223344_55667788 → if_rsp_data = 0x11223344, pulse 1 cycle, bus_addr = 0x80000000, bus_wmask = 0.
- LSU store half, addr 0x80000006, wdata 0xABCD → bus_wmask = 8'hC0, bus_wdata = 0xABCD0000_00000000, lsu_rsp_valid 1 cycle after bus_rsp_valid.
- LSU load byte, addr 0x80000003, rdata 0x00000000_AA000000 → lsu_rsp_data = 0xAA.
- Both valid in IDLE for 4 consecutive transactions:
  - Without macro, LSU is granted every time.
  - With YSYX_22040931_ARB_RR_EN: grants LSU, IF, LSU, IF.
- bus_req_ready held 0 for 5 cycles → bus_req_valid, bus_addr, bus_wdata and bus_wmask stable all 5 cycles; no requester readies asserted.
- rst pulsed during WAIT, then bus_rsp_valid → no rsp_valid pulse; next IF request completes normally.
